// File: rtl/reg_file_2w.sv
// Two-read, two-write register file with priority write port, optional
// bypass and hardwired zero entry; a clear engine zeroes all entries after reset.
module reg_file_2w #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter bit ZERO_REG = 1'b1,
    parameter bit BYPASS   = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    output logic              ready,
    input  logic              WE0,
    input  logic [ADDR_W-1:0] WN0,
    input  logic [DATA_W-1:0] WD0,
    input  logic              WE1,
    input  logic [ADDR_W-1:0] WN1,
    input  logic [DATA_W-1:0] WD1,
    input  logic [ADDR_W-1:0] RN1,
    output logic [DATA_W-1:0] RD1,
    input  logic [ADDR_W-1:0] RN2,
    output logic [DATA_W-1:0] RD2
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] FIRST = ZERO_REG ? ADDR_W'(1) : '0;
    localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(DEPTH - 1);

    localparam logic [0:0] S_CLEAR = 1'b0;
    localparam logic [0:0] S_RUN   = 1'b1;

    logic [0:0]        state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic              ready_q, ready_d;
    logic [DATA_W-1:0] mem_q [DEPTH];

    logic run;
    logic we0_eff;
    logic we1_eff;

    assign run = (state_q == S_RUN);

    // Reset cancels any write presented on the same edge.
    assign we0_eff = run && !reset && WE0 && !(ZERO_REG && (WN0 == '0));
    assign we1_eff = run && !reset && WE1 && !(ZERO_REG && (WN1 == '0));

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        ready_d = ready_q;
        if (reset) begin
            state_d = S_CLEAR;
            ptr_d   = FIRST;
            ready_d = 1'b0;
        end else if (state_q == S_CLEAR) begin
            if (ptr_q == LAST) begin
                state_d = S_RUN;
                ready_d = 1'b1;
            end else begin
                ptr_d = ptr_q + ADDR_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        state_q <= state_d;
        ptr_q   <= ptr_d;
        ready_q <= ready_d;
    end

    // Port 1 is written last so it overrides port 0 on an address clash.
    always_ff @(posedge clk) begin
        if (!reset && (state_q == S_CLEAR)) begin
            mem_q[ptr_q] <= '0;
        end else begin
            if (we0_eff) mem_q[WN0] <= WD0;
            if (we1_eff) mem_q[WN1] <= WD1;
        end
    end

    function automatic logic [DATA_W-1:0] read_port(
        input logic [ADDR_W-1:0] rn,
        input logic [DATA_W-1:0] stored,
        input logic              rdy,
        input logic              w0,
        input logic [ADDR_W-1:0] n0,
        input logic [DATA_W-1:0] d0,
        input logic              w1,
        input logic [ADDR_W-1:0] n1,
        input logic [DATA_W-1:0] d1
    );
        logic [DATA_W-1:0] v;
        v = stored;
        if (BYPASS && w0 && (n0 == rn)) v = d0;
        if (BYPASS && w1 && (n1 == rn)) v = d1;
        if (ZERO_REG && (rn == '0))      v = '0;
        if (!rdy)                        v = '0;
        return v;
    endfunction

    always_comb begin
        RD1 = read_port(RN1, mem_q[RN1], ready_q,
                        we0_eff, WN0, WD0, we1_eff, WN1, WD1);
        RD2 = read_port(RN2, mem_q[RN2], ready_q,
                        we0_eff, WN0, WD0, we1_eff, WN1, WD1);
    end

    assign ready = ready_q;

endmodule

// File: doc/reg_file_2w.md
# reg_file_2w

Parametrised multi-port register file for the pipelined MIPS datapath: two asynchronous read ports, two synchronous write ports with fixed priority, optional write-to-read bypass, optional hardwired zero register, and a sequential clear engine that zeroes every entry after reset. It replaces the fixed 32×32 single-write register file in the decode stage and lets a second writeback path (e.g. multiply/divide unit or load return) retire in the same cycle as the ALU.

## Interface
- DATA_W, 32, register width in bits
- ADDR_W, 5, register address width; DEPTH = 2**ADDR_W entries
- ZERO_REG, 1, 1: entry 0 reads as 0 and ignores writes; 0: entry 0 is an ordinary register
- BYPASS, 1, 1: a same-cycle write is forwarded to a matching read port; 0: reads return stored contents only

- clk  in  1  single clock, all state on rising edge
- reset  in  1  synchronous, active-high; starts clear sequence
- ready  out  1  1 when clear done and writes are accepted
- WE0  in  1  write enable, port 0
- WN0  in  ADDR_W  write address, port 0
- WD0  in  DATA_W  write data, port 0
- WE1  in  1  write enable, port 1 (priority port)
- WN1  in  ADDR_W  write address, port 1
- WD1  in  DATA_W  write data, port 1
- RN1  in  ADDR_W  read address, port 1
- RD1  out  DATA_W  read data, port 1 (combinational)
- RN2  in  ADDR_W  read address, port 2
- RD2  out  DATA_W  read data, port 2 (combinational)

## Operation
- States: CLEAR, RUN. Clear pointer ptr (ADDR_W bits). FIRST = 1 if ZERO_REG else 0.
- Rising edge with reset=1: state<=CLEAR, ptr<=FIRST, ready<=0; array contents unchanged on that edge.
- CLEAR, reset=0: entry[ptr]<=0; if ptr==DEPTH-1 then state<=RUN, ready<=1, else ptr<=ptr+1. WE0/WE1 ignored throughout CLEAR.
- RUN: port write effective when WEn=1 and not (ZERO_REG and WNn==0). Both effective, WN0!=WN1: both entries written. Both effective, WN0==WN1: WD1 written, WD0 dropped.
- Reads, ready=0: RD1=RD2=0.
- Reads, ready=1: RNx==0 and ZERO_REG -> 0. Else if BYPASS and an effective write in this cycle targets RNx -> that write's data (WD1 over WD0). Else entry[RNx].
- RD1/RD2 settle combinationally on any change of RNx, WEn, WNn, WDn or array contents; no registered read path.
- No wrap beyond DEPTH-1; ptr never exceeds DEPTH-1.

## Timing
- Reset values: ready=0, state=CLEAR, ptr=FIRST; RD1=RD2=0 while ready=0.
- Clear latency: DEPTH-FIRST rising edges with reset=0 after the last reset edge (31 for defaults, 32 with ZERO_REG=0). ready rises on the last of those edges.
- First accepted write: the edge after ready rises; write visible on RDx (BYPASS=0) immediately after that edge, or combinationally in the same cycle (BYPASS=1).
- reset asserted mid-clear or in RUN: next edge restarts at ptr=FIRST, ready=0; partially cleared and previously written entries are re-cleared.
- reset and WEn together: reset wins, no write.

## Test plan
- Reset 1 cycle, defaults -> ready=0 for 31 edges, ready=1 after 31st; RD1 with RN1=7 reads 0 throughout and after.
- RUN, WE0=1 WN0=5 WD0=0x1234, RN1=5, BYPASS=1 -> RD1=0x1234 in the same cycle; BYPASS=0 -> RD1=old value (0) until the edge, 0x1234 after.
- WE0=1 WN0=9 WD0=0xAAAA and WE1=1 WN1=9 WD1=0x5555 same cycle -> entry 9 = 0x5555; bypassed RD2 (RN2=9) = 0x5555.
- WE1=1 WN1=0 WD1=0xFFFF_FFFF, ZERO_REG=1 -> RD1 (RN1=0) stays 0 before and after edge; ZERO_REG=0 -> reads 0xFFFF_FFFF after edge.
- Write entries 3 and 20 with 0xDEAD_BEEF, assert reset at clear step 10 of a second reset sequence -> ready=0, restart; after 31 clean edges both entries read 0.
- WE0=1 during CLEAR (WN0=4 WD0=0x77) -> entry 4 reads 0 after ready rises.
